// File: rtl/sp_dut_harness_if.sv
// Word-stream and DUT-facing signal bundle for sp_dut_harness.
// master is the harness side; slave is the board/testbench side.
interface sp_dut_harness_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 3,
  parameter int CNT_W   = 16
);
  logic                     i_in_valid;
  logic                     o_in_ready;
  logic [WIDTH-1:0]         i_in_data;
  logic [NUM_IN*WIDTH-1:0]  o_dut_in;
  logic                     o_dut_start;
  logic [NUM_OUT*WIDTH-1:0] i_dut_out;
  logic                     o_out_valid;
  logic                     i_out_ready;
  logic [WIDTH-1:0]         o_out_data;
  logic                     o_busy;
  logic [CNT_W-1:0]         o_txn_count;

  modport master (
    input  i_in_valid, i_in_data, i_dut_out, i_out_ready,
    output o_in_ready, o_dut_in, o_dut_start, o_out_valid, o_out_data, o_busy, o_txn_count
  );

  modport slave (
    output i_in_valid, i_in_data, i_dut_out, i_out_ready,
    input  o_in_ready, o_dut_in, o_dut_start, o_out_valid, o_out_data, o_busy, o_txn_count
  );
endinterface

// File: rtl/sp_dut_harness.sv
// Serial-to-parallel stage harness: loads NUM_IN words, strobes the DUT, waits LATENCY
// cycles, captures NUM_OUT results and streams them back out one word per handshake.
module sp_dut_harness #(
  parameter int WIDTH   = 32,
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 3,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  sp_dut_harness_if.master bus
);
  localparam int IN_IDX_W  = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
  localparam int OUT_IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int LAT_W     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_UNLOAD = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IN_IDX_W-1:0]  inIdx_q, inIdx_d;
  logic [OUT_IDX_W-1:0] outIdx_q, outIdx_d;
  logic [LAT_W-1:0]     latCnt_q, latCnt_d;
  logic                 start_q, start_d;
  logic [CNT_W-1:0]     txnCount_q, txnCount_d;
  logic [WIDTH-1:0]     operand_q [NUM_IN];
  logic [WIDTH-1:0]     result_q  [NUM_OUT];

  logic inAccept, outAccept, capture, lastIn, lastOut;

  assign inAccept  = (state_q == S_LOAD) && bus.i_in_valid;
  assign outAccept = (state_q == S_UNLOAD) && bus.i_out_ready;
  assign capture   = (state_q == S_WAIT) && (latCnt_q == '0);
  assign lastIn    = (inIdx_q == IN_IDX_W'(NUM_IN - 1));
  assign lastOut   = (outIdx_q == OUT_IDX_W'(NUM_OUT - 1));

  always_comb begin
    state_d    = state_q;
    inIdx_d    = inIdx_q;
    outIdx_d   = outIdx_q;
    latCnt_d   = latCnt_q;
    txnCount_d = txnCount_q;
    start_d    = 1'b0;
    if (i_flush) begin
      state_d  = S_LOAD;
      inIdx_d  = '0;
      outIdx_d = '0;
      latCnt_d = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (inAccept) begin
            if (lastIn) begin
              inIdx_d  = '0;
              latCnt_d = LAT_W'(LATENCY);
              start_d  = 1'b1;
              state_d  = S_WAIT;
            end else begin
              inIdx_d = inIdx_q + IN_IDX_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (capture) begin
            outIdx_d = '0;
            state_d  = S_UNLOAD;
          end else begin
            latCnt_d = latCnt_q - LAT_W'(1);
          end
        end
        S_UNLOAD: begin
          if (outAccept) begin
            if (lastOut) begin
              outIdx_d   = '0;
              txnCount_d = txnCount_q + CNT_W'(1);
              state_d    = S_LOAD;
            end else begin
              outIdx_d = outIdx_q + OUT_IDX_W'(1);
            end
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= S_LOAD;
      inIdx_q    <= '0;
      outIdx_q   <= '0;
      latCnt_q   <= '0;
      start_q    <= 1'b0;
      txnCount_q <= '0;
    end else begin
      state_q    <= state_d;
      inIdx_q    <= inIdx_d;
      outIdx_q   <= outIdx_d;
      latCnt_q   <= latCnt_d;
      start_q    <= start_d;
      txnCount_q <= txnCount_d;
    end
  end

  // Operand and result words survive a flush; only reset clears them.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_IN; k++) operand_q[k] <= '0;
      for (int k = 0; k < NUM_OUT; k++) result_q[k] <= '0;
    end else if (!i_flush) begin
      if (inAccept) begin
        for (int k = 0; k < NUM_IN; k++) begin
          if (inIdx_q == IN_IDX_W'(k)) operand_q[k] <= bus.i_in_data;
        end
      end
      if (capture) begin
        for (int k = 0; k < NUM_OUT; k++) result_q[k] <= bus.i_dut_out[k*WIDTH +: WIDTH];
      end
    end
  end

  logic [NUM_IN*WIDTH-1:0] dutIn;
  logic [WIDTH-1:0]        outData;

  always_comb begin
    dutIn = '0;
    for (int k = 0; k < NUM_IN; k++) dutIn[k*WIDTH +: WIDTH] = operand_q[k];
  end

  always_comb begin
    outData = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (outIdx_q == OUT_IDX_W'(k)) outData = result_q[k];
    end
  end

  assign bus.o_in_ready  = (state_q == S_LOAD);
  assign bus.o_out_valid = (state_q == S_UNLOAD);
  assign bus.o_dut_start = start_q;
  assign bus.o_dut_in    = dutIn;
  assign bus.o_out_data  = outData;
  assign bus.o_busy      = (state_q != S_LOAD) || (inIdx_q != '0);
  assign bus.o_txn_count = txnCount_q;
endmodule

// File: tb/tb_sp_dut_harness.sv
// Directed bench for sp_dut_harness: a 3-in/3-out loopback instance plus two
// 1-in/4-out instances (LATENCY 0 and 7) fed a cycle-stamped result bus.
module tb_sp_dut_harness;
  logic clk = 1'b0;
  logic resetN;
  logic aFlush;
  logic sweepFlush;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_dut_harness_if #(.WIDTH(32), .NUM_IN(3), .NUM_OUT(3), .CNT_W(2)) aBus ();
  sp_dut_harness_if #(.WIDTH(32), .NUM_IN(1), .NUM_OUT(4), .CNT_W(16)) bBus ();
  sp_dut_harness_if #(.WIDTH(32), .NUM_IN(1), .NUM_OUT(4), .CNT_W(16)) cBus ();

  sp_dut_harness #(.WIDTH(32), .NUM_IN(3), .NUM_OUT(3), .LATENCY(1), .CNT_W(2)) dutA (
    .i_clk(clk), .i_reset(resetN), .i_flush(aFlush), .bus(aBus)
  );
  sp_dut_harness #(.WIDTH(32), .NUM_IN(1), .NUM_OUT(4), .LATENCY(0), .CNT_W(16)) dutB (
    .i_clk(clk), .i_reset(resetN), .i_flush(sweepFlush), .bus(bBus)
  );
  sp_dut_harness #(.WIDTH(32), .NUM_IN(1), .NUM_OUT(4), .LATENCY(7), .CNT_W(16)) dutC (
    .i_clk(clk), .i_reset(resetN), .i_flush(sweepFlush), .bus(cBus)
  );

  // Loopback stage for instance A: results are the operands, registered once.
  always @(posedge clk) aBus.i_dut_out <= aBus.o_dut_in;

  // Sweep instances see a result bus stamped with the current cycle number.
  logic [127:0] sweepDutOut;
  for (genvar k = 0; k < 4; k++) begin : gStamp
    assign sweepDutOut[k*32 +: 32] = {cyc[15:0], 16'(k)};
  end
  assign bBus.i_dut_out = sweepDutOut;
  assign cBus.i_dut_out = sweepDutOut;

  int          aInAccepts = 0;
  int          aStartCount = 0;
  int          aStartCyc = 0;
  logic [31:0] aOutData [$];
  int          aOutCyc [$];
  logic        aPrevStall = 1'b0;
  logic [31:0] aPrevData = '0;
  logic [31:0] bOutData [$];
  int          bOutCyc [$];
  logic [31:0] cOutData [$];
  int          cOutCyc [$];
  int          lastAcceptCyc = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Observes all handshakes one time unit after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (resetN && !aFlush) begin
      if (aBus.i_in_valid && aBus.o_in_ready) aInAccepts++;
      if (aBus.o_out_valid && aBus.i_out_ready) begin
        aOutData.push_back(aBus.o_out_data);
        aOutCyc.push_back(cyc);
      end
    end
    if (aBus.o_dut_start) begin
      aStartCount++;
      aStartCyc = cyc;
    end
    if (aPrevStall) begin
      checkOutput("stall_valid", 128'(aBus.o_out_valid), 128'(1));
      checkOutput("stall_data", 128'(aBus.o_out_data), 128'(aPrevData));
    end
    aPrevStall = resetN && !aFlush && aBus.o_out_valid && !aBus.i_out_ready;
    aPrevData  = aBus.o_out_data;
    if (bBus.o_out_valid && bBus.i_out_ready) begin
      bOutData.push_back(bBus.o_out_data);
      bOutCyc.push_back(cyc);
    end
    if (cBus.o_out_valid && cBus.i_out_ready) begin
      cOutData.push_back(cBus.o_out_data);
      cOutCyc.push_back(cyc);
    end
  end

  // Presents one word to instance A after 'gap' idle cycles; called on a falling edge.
  task automatic applyStimulus(input logic [31:0] word, input int gap);
    bit done = 1'b0;
    repeat (gap) @(negedge clk);
    aBus.i_in_data  = word;
    aBus.i_in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (aBus.o_in_ready) begin
        lastAcceptCyc = cyc;
        done = 1'b1;
      end
      @(negedge clk);
    end
    aBus.i_in_valid = 1'b0;
    if (!done) checkOutput("in_accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic applyTxn(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          output int firstAcc);
    applyStimulus(w0, 0);
    firstAcc = lastAcceptCyc;
    applyStimulus(w1, 0);
    applyStimulus(w2, 0);
  endtask

  task automatic waitOutputs(input int n);
    for (int t = 0; t < 60 && aOutData.size() < n; t++) @(negedge clk);
    checkOutput("out_count", 128'(aOutData.size()), 128'(n));
  endtask

  task automatic checkWords(input string tag, input int base,
                            input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    checkOutput({tag, "_w0"}, 128'(aOutData[base]), 128'(w0));
    checkOutput({tag, "_w1"}, 128'(aOutData[base+1]), 128'(w1));
    checkOutput({tag, "_w2"}, 128'(aOutData[base+2]), 128'(w2));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int firstAcc, base, startBase, acceptBase, nAcc;
    int wrapSeq [5] = '{1, 2, 3, 0, 1};
    logic [31:0] expWord;
    logic [15:0] stamp;

    resetN = 1'b0;
    aFlush = 1'b0;
    sweepFlush = 1'b0;
    aBus.i_in_valid = 1'b0;
    aBus.i_in_data  = '0;
    aBus.i_out_ready = 1'b1;
    bBus.i_in_valid = 1'b0;
    bBus.i_in_data  = '0;
    bBus.i_out_ready = 1'b1;
    cBus.i_in_valid = 1'b0;
    cBus.i_in_data  = '0;
    cBus.i_out_ready = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_in_ready", 128'(aBus.o_in_ready), 128'(1));
    checkOutput("rst_dut_in", 128'(aBus.o_dut_in), 128'(0));
    checkOutput("rst_start", 128'(aBus.o_dut_start), 128'(0));
    checkOutput("rst_out_valid", 128'(aBus.o_out_valid), 128'(0));
    checkOutput("rst_out_data", 128'(aBus.o_out_data), 128'(0));
    checkOutput("rst_busy", 128'(aBus.o_busy), 128'(0));
    checkOutput("rst_txn", 128'(aBus.o_txn_count), 128'(0));
    resetN = 1'b1;
    @(negedge clk);

    // Basic transaction with ready held high.
    base = aOutData.size();
    startBase = aStartCount;
    applyTxn(32'h11, 32'h22, 32'h33, firstAcc);
    checkOutput("basic_dut_in", 128'(aBus.o_dut_in), 128'({32'h33, 32'h22, 32'h11}));
    checkOutput("basic_start_high", 128'(aBus.o_dut_start), 128'(1));
    waitOutputs(base + 3);
    checkWords("basic", base, 32'h11, 32'h22, 32'h33);
    checkOutput("basic_start_pulses", 128'(aStartCount - startBase), 128'(1));
    checkOutput("basic_start_cyc", 128'(aStartCyc), 128'(lastAcceptCyc + 1));
    checkOutput("basic_last_out_cyc", 128'(aOutCyc[base+2]), 128'(firstAcc + 7));
    checkOutput("basic_txn", 128'(aBus.o_txn_count), 128'(1));
    checkOutput("basic_ready_back", 128'(aBus.o_in_ready), 128'(1));

    // Input gaps, then consumer stalls for five cycles after the first word.
    base = aOutData.size();
    acceptBase = aInAccepts;
    applyStimulus(32'hA1, 1);
    applyStimulus(32'hB2, 3);
    applyStimulus(32'hC3, 2);
    waitOutputs(base + 1);
    aBus.i_out_ready = 1'b0;
    repeat (5) @(negedge clk);
    aBus.i_out_ready = 1'b1;
    waitOutputs(base + 3);
    checkWords("bp", base, 32'hA1, 32'hB2, 32'hC3);
    checkOutput("bp_accepts", 128'(aInAccepts - acceptBase), 128'(3));
    checkOutput("bp_txn", 128'(aBus.o_txn_count), 128'(2));

    // Flush on the same cycle as the third word.
    acceptBase = aInAccepts;
    applyStimulus(32'h01, 0);
    applyStimulus(32'h02, 0);
    checkOutput("flush_busy_mid", 128'(aBus.o_busy), 128'(1));
    aBus.i_in_data  = 32'h03;
    aBus.i_in_valid = 1'b1;
    aFlush = 1'b1;
    @(negedge clk);
    aBus.i_in_valid = 1'b0;
    aFlush = 1'b0;
    checkOutput("flush_ready", 128'(aBus.o_in_ready), 128'(1));
    checkOutput("flush_busy", 128'(aBus.o_busy), 128'(0));
    checkOutput("flush_retained", 128'(aBus.o_dut_in), 128'({32'hC3, 32'h02, 32'h01}));
    checkOutput("flush_accepts", 128'(aInAccepts - acceptBase), 128'(2));
    base = aOutData.size();
    applyTxn(32'h04, 32'h05, 32'h06, firstAcc);
    checkOutput("flush_clean_dut_in", 128'(aBus.o_dut_in), 128'({32'h06, 32'h05, 32'h04}));
    waitOutputs(base + 3);
    checkWords("flush_clean", base, 32'h04, 32'h05, 32'h06);
    checkOutput("flush_clean_txn", 128'(aBus.o_txn_count), 128'(3));

    // Flush while results are waiting to be unloaded.
    aBus.i_out_ready = 1'b0;
    base = aOutData.size();
    applyTxn(32'h07, 32'h08, 32'h09, firstAcc);
    for (int t = 0; t < 20 && !aBus.o_out_valid; t++) @(negedge clk);
    checkOutput("uflush_valid_before", 128'(aBus.o_out_valid), 128'(1));
    aFlush = 1'b1;
    @(negedge clk);
    aFlush = 1'b0;
    checkOutput("uflush_valid_drop", 128'(aBus.o_out_valid), 128'(0));
    checkOutput("uflush_txn", 128'(aBus.o_txn_count), 128'(3));
    checkOutput("uflush_ready", 128'(aBus.o_in_ready), 128'(1));
    checkOutput("uflush_no_out", 128'(aOutData.size()), 128'(base));
    aBus.i_out_ready = 1'b1;

    // Reset in the first WAIT cycle.
    base = aOutData.size();
    applyTxn(32'h0A, 32'h0B, 32'h0C, firstAcc);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    checkOutput("wrst_in_ready", 128'(aBus.o_in_ready), 128'(1));
    checkOutput("wrst_dut_in", 128'(aBus.o_dut_in), 128'(0));
    checkOutput("wrst_start", 128'(aBus.o_dut_start), 128'(0));
    checkOutput("wrst_out_valid", 128'(aBus.o_out_valid), 128'(0));
    checkOutput("wrst_out_data", 128'(aBus.o_out_data), 128'(0));
    checkOutput("wrst_busy", 128'(aBus.o_busy), 128'(0));
    checkOutput("wrst_txn", 128'(aBus.o_txn_count), 128'(0));
    repeat (4) @(negedge clk);
    checkOutput("wrst_no_unload", 128'(aOutData.size()), 128'(base));
    checkOutput("wrst_no_capture", 128'(aBus.o_out_data), 128'(0));

    // Two-bit transaction counter wraps after four transactions.
    for (int i = 0; i < 5; i++) begin
      base = aOutData.size();
      applyTxn(32'(16 * i + 1), 32'(16 * i + 2), 32'(16 * i + 3), firstAcc);
      waitOutputs(base + 3);
      checkOutput("wrap_last_word", 128'(aOutData[base+2]), 128'(16 * i + 3));
      checkOutput("wrap_txn", 128'(aBus.o_txn_count), 128'(wrapSeq[i]));
    end

    // One word into both sweep instances on the same cycle.
    bBus.i_in_data  = 32'h5A;
    cBus.i_in_data  = 32'hC5;
    bBus.i_in_valid = 1'b1;
    cBus.i_in_valid = 1'b1;
    checkOutput("sweep_b_ready", 128'(bBus.o_in_ready), 128'(1));
    checkOutput("sweep_c_ready", 128'(cBus.o_in_ready), 128'(1));
    nAcc = cyc;
    @(negedge clk);
    bBus.i_in_valid = 1'b0;
    cBus.i_in_valid = 1'b0;
    checkOutput("sweep_b_dut_in", 128'(bBus.o_dut_in), 128'(32'h5A));
    checkOutput("sweep_c_dut_in", 128'(cBus.o_dut_in), 128'(32'hC5));
    checkOutput("sweep_b_start", 128'(bBus.o_dut_start), 128'(1));
    checkOutput("sweep_c_start", 128'(cBus.o_dut_start), 128'(1));
    @(negedge clk);
    checkOutput("sweep_b_start_off", 128'(bBus.o_dut_start), 128'(0));
    checkOutput("sweep_c_start_off", 128'(cBus.o_dut_start), 128'(0));
    repeat (20) @(negedge clk);
    checkOutput("sweep_b_count", 128'(bOutData.size()), 128'(4));
    checkOutput("sweep_c_count", 128'(cOutData.size()), 128'(4));
    for (int k = 0; k < 4; k++) begin
      stamp = 16'(nAcc + 1);
      expWord = {stamp, 16'(k)};
      checkOutput("sweep_b_word", 128'(bOutData[k]), 128'(expWord));
      checkOutput("sweep_b_cyc", 128'(bOutCyc[k]), 128'(nAcc + 2 + k));
      stamp = 16'(nAcc + 8);
      expWord = {stamp, 16'(k)};
      checkOutput("sweep_c_word", 128'(cOutData[k]), 128'(expWord));
      checkOutput("sweep_c_cyc", 128'(cOutCyc[k]), 128'(nAcc + 9 + k));
    end
    checkOutput("sweep_c_txn", 128'(cBus.o_txn_count), 128'(1));
    checkOutput("sweep_b_busy", 128'(bBus.o_busy), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sp_dut_harness.md
# sp_dut_harness

Parametrised serial-to-parallel test harness for pipeline-stage verification. It loads NUM_IN words of WIDTH bits one at a time through a valid/ready input stream and presents them in parallel to a device under test. It then pulses a start strobe, waits LATENCY cycles, captures NUM_OUT parallel result words, and streams them back out one word per handshake. It sits between the board/testbench word interface and any stage (ID, EX, MEM) exposed by a verification top. It replaces fixed 3-in/3-out SIPO/PISO pairs with enable-only control.

## Interface
- WIDTH, 32, bits per word
- NUM_IN, 3, words loaded per transaction (≥1)
- NUM_OUT, 3, words captured/unloaded per transaction (≥1)
- LATENCY, 1, cycles from start strobe to capture (≥0)
- CNT_W, 16, width of transaction counter
---
- i_clk  in  1  single clock; all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_flush  in  1  synchronous abort of current transaction
- i_in_valid  in  1  input word valid
- o_in_ready  out  1  harness accepts input word
- i_in_data  in  WIDTH  input word
- o_dut_in  out  NUM_IN*WIDTH  parallel operands; word k at [k*WIDTH +: WIDTH], word 0 = first received
- o_dut_start  out  1  one-cycle strobe, operands complete
- i_dut_out  in  NUM_OUT*WIDTH  DUT results; word k at [k*WIDTH +: WIDTH]
- o_out_valid  out  1  output word valid
- i_out_ready  in  1  consumer accepts output word
- o_out_data  out  WIDTH  output word, word 0 first
- o_busy  out  1  transaction in progress
- o_txn_count  out  CNT_W  completed transactions, wraps

## Operation
- States: LOAD, WAIT, UNLOAD. Reset state is LOAD.
- LOAD:
  - o_in_ready=1.
  - On i_in_valid&&o_in_ready, write i_in_data into operand slot in_idx, then in_idx++.
  - On accepting slot NUM_IN-1: in_idx←0, lat_cnt←LATENCY, o_dut_start←1 (registered), go to WAIT.
- WAIT:
  - o_in_ready=0, o_dut_start high in first WAIT cycle only.
  - Each cycle: if lat_cnt==0, capture all of i_dut_out into result regs, out_idx←0, go to UNLOAD; else lat_cnt--.
- UNLOAD:
  - o_out_valid=1, o_out_data=result[out_idx].
  - On o_out_valid&&i_out_ready, out_idx++.
  - On last word (NUM_OUT-1): out_idx←0, o_txn_count++ (wraps 2^CNT_W-1→0), go to LOAD.
- Operand slots hold their value until overwritten by the next transaction's word in that slot. Result regs hold until the next capture.
- o_busy = (state≠LOAD) || (in_idx≠0).
- i_flush=1: state←LOAD, in_idx/out_idx/lat_cnt←0, o_dut_start←0. Operand/result data and o_txn_count are retained. Flush has priority over any same-cycle handshake (the word is not accepted and not counted).
- i_reset=0 (any state, mid-transaction included): all registers zero, state LOAD. Reset has priority over flush.
- i_in_valid is ignored outside LOAD. i_out_ready is ignored outside UNLOAD. Data is never lost or duplicated under arbitrary valid/ready stalls.
- NUM_IN=1 and NUM_OUT=1 are supported. Index widths are $clog2 of the count, minimum 1.

## Timing
- Reset values: o_in_ready=1 (LOAD), o_dut_in=0, o_dut_start=0, o_out_valid=0, o_out_data=0, o_busy=0, o_txn_count=0.
- Last input accepted at edge E0:
  - o_dut_in is complete in cycle T=E0+1.
  - o_dut_start=1 in cycle T.
- i_dut_out is sampled at the edge ending cycle T+LATENCY.
  - LATENCY=0 samples at the end of cycle T, so the DUT is purely combinational.
- First o_out_valid occurs in cycle T+LATENCY+1.
- With ready always high, a full transaction takes NUM_IN + 1 + LATENCY + NUM_OUT cycles, and o_in_ready reasserts the cycle after the last output handshake.
- All outputs are registered or decoded from state only. There is no combinational path from i_in_valid/i_out_ready to any output.

## Test plan
- **Basic transaction.** Defaults, no stalls. Feed 0x11,0x22,0x33; DUT loopback i_dut_out=o_dut_in registered once.
  - o_dut_start exactly one cycle, 1 cycle after 3rd accept.
  - Outputs 0x11,0x22,0x33 in order.
  - o_txn_count=1.
- **Backpressure.**
  - Random i_in_valid gaps and i_out_ready low for 5 cycles mid-unload.
  - o_out_data stable while stalled; exact word sequence preserved; no extra accepts.
- **Parametric sweep.** NUM_IN=1/NUM_OUT=4, LATENCY=0 and LATENCY=7.
  - Capture edge is exactly T+LATENCY (DUT output changes one cycle later must not be seen).
  - Four words out.
- **Flush.** Assert i_flush after 2 of 3 words, same cycle as a valid input.
  - Word not accepted; state LOAD; next 3 words form a clean transaction.
  - Flush during UNLOAD: o_out_valid drops next cycle; count unchanged.
- **Reset mid-WAIT.** i_reset=0 for one cycle.
  - All outputs at reset values next cycle.
  - No capture or unload occurs.
- **Counter wrap.** CNT_W=2, 5 transactions → o_txn_count sequence 1,2,3,0,1.
